// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: default address geometry, vectors and the PC source select.
package cpu_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned DEF_STEP         = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEF_RAS_DEPTH    = 4;

    // Listed in decreasing priority.
    typedef enum logic [2:0] {
        SrcTrap,
        SrcHold,
        SrcRet,
        SrcTarget,
        SrcSeq
    } pc_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control and status bundle between the fetch control logic and the program counter.
interface pc_unit_if #(
    parameter int unsigned WIDTH = cpu_pkg::XLEN
);
    logic             stall;
    logic             branch_taken;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] branch_target;
    logic             trap;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_next;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_miss;

    modport master (
        output stall, branch_taken, call, ret, branch_target, trap,
        input  pc_out, pc_next, ras_empty, ras_full, ras_miss
    );

    modport slave (
        input  stall, branch_taken, call, ret, branch_target, trap,
        output pc_out, pc_next, ras_empty, ras_full, ras_miss
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; pushing when full silently overwrites the oldest entry.
module pc_ras
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN,
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_idx;

    assign top_idx = ptr_q - PTR_W'(1);
    assign top     = entry_q[top_idx];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));

    always_comb begin
        entry_d = entry_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            entry_d[ptr_q] = push_data;
            ptr_d          = ptr_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC selection plus call/return prediction.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH        = XLEN,
    parameter int unsigned STEP         = DEF_STEP,
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
    parameter int unsigned RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.slave    bus
);
    localparam logic [WIDTH-1:0] RST_VEC  = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] TRAP_VEC = WIDTH'(TRAP_VECTOR);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             ras_miss_q, ras_miss_d;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_push;
    logic             ras_pop;
    logic             redirect_ok;
    pc_src_e          pc_src;

    assign pc_seq      = pc_q + WIDTH'(STEP);
    // RAS and miss tracking only move in cycles that actually advance normally.
    assign redirect_ok = !bus.stall && !bus.trap;
    assign ras_push    = redirect_ok && bus.call && !bus.ret;
    assign ras_pop     = redirect_ok && bus.ret && !ras_empty;

    always_comb begin
        if (bus.trap) begin
            pc_src = SrcTrap;
        end else if (bus.stall) begin
            pc_src = SrcHold;
        end else if (bus.ret) begin
            pc_src = SrcRet;
        end else if (bus.call || bus.branch_taken) begin
            pc_src = SrcTarget;
        end else begin
            pc_src = SrcSeq;
        end
    end

    always_comb begin
        pc_d = pc_seq;
        if (rst) begin
            pc_d = RST_VEC;
        end else begin
            unique case (pc_src)
                SrcTrap:   pc_d = TRAP_VEC;
                SrcHold:   pc_d = pc_q;
                SrcRet:    pc_d = ras_empty ? bus.branch_target : ras_top;
                SrcTarget: pc_d = bus.branch_target;
                SrcSeq:    pc_d = pc_seq;
                default:   pc_d = pc_seq;
            endcase
        end
    end

    assign ras_miss_d = redirect_ok && bus.ret && ras_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RST_VEC;
            ras_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ras_miss_q <= ras_miss_d;
        end
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign bus.pc_out    = pc_q;
    assign bus.pc_next   = pc_d;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_miss  = ras_miss_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for the main flow and an 8-bit one for wrap.
module tb_pc_unit;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   failures;

    pc_unit_if #(.WIDTH(32)) bus_a ();
    pc_unit_if #(.WIDTH(8))  bus_b ();

    pc_unit #(.WIDTH(32)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    pc_unit #(.WIDTH(8)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.stall = 0; bus_a.branch_taken = 0; bus_a.call = 0;
        bus_a.ret = 0; bus_a.trap = 0; bus_a.branch_target = '0;
    endtask

    task automatic idle_b();
        bus_b.stall = 0; bus_b.branch_taken = 0; bus_b.call = 0;
        bus_b.ret = 0; bus_b.trap = 0; bus_b.branch_target = '0;
    endtask

    logic [31:0] call_ret [5];

    initial begin
        checks = 0;
        failures = 0;
        idle_a();
        idle_b();
        rst_a = 1;
        rst_b = 1;
        bus_a.trap = 1;
        #1;
        check_val("pc_next_in_reset", bus_a.pc_next, 32'h0);
        tick();
        bus_a.trap = 0;
        tick();
        check_val("reset_pc", bus_a.pc_out, 32'h0);
        check_val("reset_empty", 32'(bus_a.ras_empty), 32'h1);
        check_val("reset_full", 32'(bus_a.ras_full), 32'h0);
        check_val("reset_miss", 32'(bus_a.ras_miss), 32'h0);
        rst_a = 0;
        rst_b = 0;
        #1;
        check_val("pc_next_after_reset", bus_a.pc_next, 32'h4);

        // Free run
        for (int i = 1; i <= 4; i++) begin
            if (i == 3) begin
                // Stall at pc_out=8 for three edges
                bus_a.stall = 1;
                #1;
                check_val("stall_pc_next", bus_a.pc_next, 32'h8);
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check_val("stall_hold", bus_a.pc_out, 32'h8);
                end
                bus_a.stall = 0;
            end
            tick();
            check_val("free_run", bus_a.pc_out, 32'(4 * i));
            check_val("free_run_empty", 32'(bus_a.ras_empty), 32'h1);
        end
        // pc_out now 0x10
        bus_a.branch_taken = 1;
        bus_a.branch_target = 32'h40;
        #1;
        check_val("branch_pc_next", bus_a.pc_next, 32'h40);
        tick();
        check_val("branch_pc", bus_a.pc_out, 32'h40);
        idle_a();
        tick();
        check_val("after_branch", bus_a.pc_out, 32'h44);
        bus_a.call = 1;
        bus_a.branch_target = 32'h80;
        tick();
        check_val("call_pc", bus_a.pc_out, 32'h80);
        check_val("call_nonempty", 32'(bus_a.ras_empty), 32'h0);
        idle_a();
        tick();
        check_val("after_call", bus_a.pc_out, 32'h84);
        bus_a.ret = 1;
        bus_a.branch_target = 32'h999;
        #1;
        check_val("ret_pc_next", bus_a.pc_next, 32'h48);
        tick();
        check_val("ret_pc", bus_a.pc_out, 32'h48);
        check_val("ret_empty", 32'(bus_a.ras_empty), 32'h1);
        check_val("ret_no_miss", 32'(bus_a.ras_miss), 32'h0);

        // Five nested calls from 0x48 into a 4-deep RAS
        call_ret = '{32'h4C, 32'h204, 32'h404, 32'h604, 32'h804};
        idle_a();
        bus_a.call = 1;
        for (int i = 0; i < 5; i++) begin
            bus_a.branch_target = 32'(32'h200 * (i + 1));
            tick();
            check_val("nest_call_pc", bus_a.pc_out, 32'(32'h200 * (i + 1)));
            if (i == 3) check_val("nest_full", 32'(bus_a.ras_full), 32'h1);
        end
        idle_a();
        bus_a.ret = 1;
        bus_a.branch_target = 32'hF00;
        for (int i = 4; i >= 1; i--) begin
            tick();
            check_val("nest_ret_pc", bus_a.pc_out, call_ret[i]);
            check_val("nest_ret_no_miss", 32'(bus_a.ras_miss), 32'h0);
        end
        check_val("nest_drained", 32'(bus_a.ras_empty), 32'h1);
        tick();
        check_val("miss_pc", bus_a.pc_out, 32'hF00);
        check_val("miss_pulse", 32'(bus_a.ras_miss), 32'h1);
        idle_a();
        tick();
        check_val("miss_clear", 32'(bus_a.ras_miss), 32'h0);
        check_val("after_miss_pc", bus_a.pc_out, 32'hF04);

        // Reach 0x20 with one RAS entry (0x1C), then trap with stall and call
        bus_a.branch_taken = 1;
        bus_a.branch_target = 32'h18;
        tick();
        idle_a();
        bus_a.call = 1;
        bus_a.branch_target = 32'h20;
        tick();
        check_val("pre_trap_pc", bus_a.pc_out, 32'h20);
        bus_a.trap = 1;
        bus_a.stall = 1;
        bus_a.branch_target = 32'h300;
        #1;
        check_val("trap_pc_next", bus_a.pc_next, 32'h100);
        tick();
        check_val("trap_pc", bus_a.pc_out, 32'h100);
        check_val("trap_ras_kept", 32'(bus_a.ras_empty), 32'h0);
        idle_a();
        bus_a.ret = 1;
        tick();
        check_val("trap_no_push", bus_a.pc_out, 32'h1C);
        check_val("trap_count_one", 32'(bus_a.ras_empty), 32'h1);
        idle_a();
        bus_a.call = 1;
        bus_a.branch_target = 32'h40;
        tick();
        check_val("refill", 32'(bus_a.ras_empty), 32'h0);
        rst_a = 1;
        bus_a.trap = 1;
        tick();
        check_val("rst_over_trap_pc", bus_a.pc_out, 32'h0);
        check_val("rst_ras_clear", 32'(bus_a.ras_empty), 32'h1);
        rst_a = 0;
        idle_a();
        bus_a.ret = 1;
        bus_a.branch_target = 32'h55C;
        tick();
        check_val("rst_ret_pc", bus_a.pc_out, 32'h55C);
        check_val("rst_ret_miss", 32'(bus_a.ras_miss), 32'h1);
        idle_a();

        // 8-bit instance: wrap and ret+call together
        rst_b = 1;
        tick();
        rst_b = 0;
        bus_b.branch_taken = 1;
        bus_b.branch_target = 8'hF8;
        tick();
        idle_b();
        bus_b.call = 1;
        bus_b.branch_target = 8'hFC;
        tick();
        check_val("w8_call_pc", 32'(bus_b.pc_out), 32'hFC);
        idle_b();
        #1;
        check_val("w8_wrap_next", 32'(bus_b.pc_next), 32'h00);
        tick();
        check_val("w8_wrap_pc", 32'(bus_b.pc_out), 32'h00);
        bus_b.ret = 1;
        bus_b.call = 1;
        bus_b.branch_target = 8'h10;
        tick();
        check_val("w8_retcall_pc", 32'(bus_b.pc_out), 32'hFC);
        check_val("w8_retcall_empty", 32'(bus_b.ras_empty), 32'h1);
        check_val("w8_retcall_miss", 32'(bus_b.ras_miss), 32'h0);
        idle_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
